// File: rtl/load_store_unit.sv
// MEM-stage load/store controller driving a big-endian word/double data memory.
// Ports: Req_* from EX/MEM, *_MEM memory port, Load_* result, Exc_* fault. Macro: LSU_RANGE_CHECK_EN.
module load_store_unit #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Req_valid,
  output logic              Req_ready,
  input  logic [3:0]        Req_op,
  input  logic [ADDR_W-1:0] Req_addr,
  input  logic [63:0]       Req_wdata,
  output logic [ADDR_W-1:0] Adrs_MEM,
  output logic [31:0]       Rt_data_MEM,
  output logic [63:0]       Rt_data64_MEM,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              MemWrite64,
  input  logic [31:0]       OUT_data_MEM,
  input  logic [31:0]       OUT_nextdata_MEM,
  output logic              Load_valid,
  output logic [31:0]       Load_data,
  output logic [31:0]       Load_data_lo,
  output logic              Exc_valid,
  output logic [1:0]        Exc_code
);

  localparam logic [3:0] OP_LW  = 4'd0;
  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LD  = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [3:0] OP_SB  = 4'd9;
  localparam logic [3:0] OP_SH  = 4'd10;
  localparam logic [3:0] OP_SD  = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RMW_RD,
    S_RMW_WR
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;
  logic              load_valid_q, load_valid_d;
  logic [31:0]       load_data_q, load_data_d;
  logic [31:0]       load_lo_q, load_lo_d;
  logic              exc_valid_q, exc_valid_d;
  logic [1:0]        exc_code_q, exc_code_d;

  // request decode
  logic       dec_legal;
  logic       dec_load;
  logic       dec_rmw;
  logic [2:0] dec_amask;
  logic       dec_misal;
  logic       dec_range;

  always_comb begin
    dec_legal = 1'b1;
    dec_load  = 1'b0;
    dec_rmw   = 1'b0;
    dec_amask = 3'd0;
    unique case (Req_op)
      OP_LW:  begin dec_load = 1'b1; dec_amask = 3'd3; end
      OP_LB:  begin dec_load = 1'b1; end
      OP_LBU: begin dec_load = 1'b1; end
      OP_LH:  begin dec_load = 1'b1; dec_amask = 3'd1; end
      OP_LHU: begin dec_load = 1'b1; dec_amask = 3'd1; end
      OP_LD:  begin dec_load = 1'b1; dec_amask = 3'd7; end
      OP_SW:  begin dec_amask = 3'd3; end
      OP_SB:  begin dec_rmw = 1'b1; end
      OP_SH:  begin dec_rmw = 1'b1; dec_amask = 3'd1; end
      OP_SD:  begin dec_amask = 3'd7; end
      default: dec_legal = 1'b0;
    endcase
    dec_misal = |(Req_addr[2:0] & dec_amask);
  end

`ifdef LSU_RANGE_CHECK_EN
  localparam int AW1 = ADDR_W + 1;
  logic [3:0] dec_size;

  always_comb begin
    unique case (Req_op)
      OP_LB, OP_LBU, OP_SB: dec_size = 4'd1;
      OP_LH, OP_LHU, OP_SH: dec_size = 4'd2;
      OP_LD, OP_SD:         dec_size = 4'd8;
      default:              dec_size = 4'd4;
    endcase
    // one extra bit so addr + size cannot wrap
    dec_range = ({1'b0, Req_addr} + AW1'(dec_size)) > AW1'(MEM_BYTES);
  end
`else
  assign dec_range = 1'b0;
`endif

  // every access is issued at the containing word address
  logic [ADDR_W-1:0] mem_addr;
  assign mem_addr = (addr_q % ADDR_W'(MEM_BYTES)) & ~ADDR_W'(3);

  // load extraction / store merge, k = byte offset in the word
  logic [1:0]  k;
  logic [4:0]  bsh;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ext;
  logic [31:0] bmask;
  logic [31:0] merged;

  assign k   = addr_q[1:0];
  assign bsh = {~k, 3'b000};

  always_comb begin
    rd_byte = 8'(OUT_data_MEM >> bsh);
    rd_half = k[1] ? OUT_data_MEM[15:0] : OUT_data_MEM[31:16];
    unique case (op_q)
      OP_LB:   ext = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  ext = {24'd0, rd_byte};
      OP_LH:   ext = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  ext = {16'd0, rd_half};
      default: ext = OUT_data_MEM;
    endcase
    bmask = 32'hFF << bsh;
    if (op_q == OP_SH) begin
      merged = k[1] ? {OUT_data_MEM[31:16], wdata_q[15:0]}
                    : {wdata_q[15:0], OUT_data_MEM[15:0]};
    end else begin
      merged = (OUT_data_MEM & ~bmask)
             | (32'(wdata_q[7:0]) << bsh);
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    merge_d      = merge_q;
    load_valid_d = 1'b0;
    load_data_d  = load_data_q;
    load_lo_d    = load_lo_q;
    exc_valid_d  = 1'b0;
    exc_code_d   = 2'd0;
    unique case (state_q)
      S_IDLE: begin
        if (Req_valid) begin
          op_d    = Req_op;
          addr_d  = Req_addr;
          wdata_d = Req_wdata;
          if (!dec_legal) begin
            exc_valid_d = 1'b1;
            exc_code_d  = 2'd3;
          end else if (dec_misal) begin
            exc_valid_d = 1'b1;
            exc_code_d  = 2'd1;
          end else if (dec_range) begin
            exc_valid_d = 1'b1;
            exc_code_d  = 2'd2;
          end else if (dec_load) begin
            state_d = S_RD;
          end else if (dec_rmw) begin
            state_d = S_RMW_RD;
          end else begin
            state_d = S_WR;
          end
        end
      end
      S_RD: begin
        load_valid_d = 1'b1;
        load_data_d  = ext;
        load_lo_d    = (op_q == OP_LD) ? OUT_nextdata_MEM : 32'd0;
        state_d      = S_IDLE;
      end
      S_RMW_RD: begin
        merge_d = merged;
        state_d = S_RMW_WR;
      end
      S_RMW_WR: state_d = S_IDLE;
      S_WR:     state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= S_IDLE;
      op_q         <= 4'd0;
      addr_q       <= '0;
      wdata_q      <= 64'd0;
      merge_q      <= 32'd0;
      load_valid_q <= 1'b0;
      load_data_q  <= 32'd0;
      load_lo_q    <= 32'd0;
      exc_valid_q  <= 1'b0;
      exc_code_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      merge_q      <= merge_d;
      load_valid_q <= load_valid_d;
      load_data_q  <= load_data_d;
      load_lo_q    <= load_lo_d;
      exc_valid_q  <= exc_valid_d;
      exc_code_q   <= exc_code_d;
    end
  end

  // strobes decode straight from state so async reset drops them at once
  logic st_wr;
  assign st_wr = (state_q == S_WR);

  assign Req_ready     = (state_q == S_IDLE);
  assign MemRead       = (state_q == S_RD) || (state_q == S_RMW_RD);
  assign MemWrite      = (state_q == S_RMW_WR) || (st_wr && op_q != OP_SD);
  assign MemWrite64    = st_wr && (op_q == OP_SD);
  assign Adrs_MEM      = Req_ready ? '0 : mem_addr;
  assign Rt_data_MEM   = (state_q == S_RMW_WR) ? merge_q
                       : (st_wr && op_q == OP_SW) ? wdata_q[31:0]
                       : 32'd0;
  assign Rt_data64_MEM = MemWrite64 ? wdata_q : 64'd0;
  assign Load_valid    = load_valid_q;
  assign Load_data     = load_data_q;
  assign Load_data_lo  = load_lo_q;
  assign Exc_valid     = exc_valid_q;
  assign Exc_code      = exc_code_q;

endmodule
